// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirect
// flush windows, data-memory wait freezing and a saturating stall counter.
module hazard_stall_controller #(
  parameter int FLUSH_CYCLES     = 2,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             rs1_decode,
  input  logic [4:0]             rs2_decode,
  input  logic                   rs1_used,
  input  logic                   rs2_used,
  input  logic [4:0]             rd_execute,
  input  logic                   memRead_execute,
  input  logic [1:0]             next_PC_select_execute,
  input  logic                   d_mem_req,
  input  logic                   d_mem_ready,
  output logic                   stall_fetch,
  output logic                   stall_decode,
  output logic                   flush_decode,
  output logic                   stall_memory,
  output logic [1:0]             ctrl_state,
  output logic [COUNT_WIDTH-1:0] stall_cycles
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LOAD_USE = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;
  localparam logic [1:0] MEM_WAIT = 2'd3;

  localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] BUBBLE_INIT = 3'(LOAD_USE_BUBBLES - 1);
  localparam logic [1:0] FLUSH_DEST  = (FLUSH_CYCLES > 1) ? REDIRECT : RUN;
  localparam logic [1:0] BUBBLE_DEST = (LOAD_USE_BUBBLES > 1) ? LOAD_USE : RUN;

  logic [1:0] state, state_next;
  logic [1:0] ret_state, ret_next;
  logic [2:0] cnt, cnt_next;
  logic       hazard, mem_block, redirect;
  logic       stall_f, stall_d, flush_d, stall_m;

  assign hazard = memRead_execute && (rd_execute != 5'd0) &&
                  ((rs1_used && (rs1_decode == rd_execute)) ||
                   (rs2_used && (rs2_decode == rd_execute)));
  assign mem_block = d_mem_req && !d_mem_ready;
  assign redirect  = (next_PC_select_execute != 2'd0);

  // Priority inside every active state is mem_block > redirect > hazard;
  // entering MEM_WAIT freezes cnt and remembers where to resume.
  always_comb begin
    state_next = state;
    ret_next   = ret_state;
    cnt_next   = cnt;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    stall_m    = 1'b0;
    case (state)
      RUN: begin
        if (mem_block) begin
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          stall_m    = 1'b1;
          ret_next   = RUN;
          state_next = MEM_WAIT;
        end else if (redirect) begin
          flush_d    = 1'b1;
          cnt_next   = FLUSH_INIT;
          state_next = FLUSH_DEST;
        end else if (hazard) begin
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          cnt_next   = BUBBLE_INIT;
          state_next = BUBBLE_DEST;
        end
      end
      LOAD_USE: begin
        if (mem_block) begin
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          stall_m    = 1'b1;
          ret_next   = LOAD_USE;
          state_next = MEM_WAIT;
        end else if (redirect) begin
          flush_d    = 1'b1;
          cnt_next   = FLUSH_INIT;
          state_next = FLUSH_DEST;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          if (cnt <= 3'd1) begin
            state_next = RUN;
          end else begin
            cnt_next = cnt - 3'd1;
          end
        end
      end
      REDIRECT: begin
        // A redirect seen here comes from a squashed instruction and is ignored.
        if (mem_block) begin
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          stall_m    = 1'b1;
          ret_next   = REDIRECT;
          state_next = MEM_WAIT;
        end else begin
          flush_d = 1'b1;
          if (cnt <= 3'd1) begin
            state_next = RUN;
          end else begin
            cnt_next = cnt - 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_m = 1'b1;
        if (d_mem_ready) begin
          state_next = ret_state;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= 3'd0;
    end else begin
      state     <= state_next;
      ret_state <= ret_next;
      cnt       <= cnt_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall_d && (stall_cycles != {COUNT_WIDTH{1'b1}})) begin
      stall_cycles <= stall_cycles + COUNT_WIDTH'(1);
    end
  end

  // Outputs are forced quiet for the whole time reset is held.
  assign stall_fetch  = stall_f && !reset;
  assign stall_decode = stall_d && !reset;
  assign flush_decode = flush_d && !reset;
  assign stall_memory = stall_m && !reset;
  assign ctrl_state   = state;

endmodule
